// File: rtl/run_supervisor.sv
// run_supervisor: core reset sequencing, halt/error/timeout monitoring and a registered run verdict
module run_supervisor #(
   parameter int NUM_CORES = 2,
   parameter int NUM_LANES = 8,
   parameter int NUM_ERR   = 3,
   parameter int TIMEOUT_W = 32,
   parameter int RST_HOLD  = 2,
   parameter int ERR_DRAIN = 5,
   parameter int HALT_MODE = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CORES*NUM_LANES-1:0] halt,
   input  logic [NUM_ERR-1:0]             err,
   input  logic [TIMEOUT_W-1:0]           timeout_cycles,
   output logic                           core_rst,
   output logic                           running,
   output logic                           done,
   output logic                           pass,
   output logic                           fail_timeout,
   output logic                           fail_error,
   output logic [NUM_ERR-1:0]             err_src,
   output logic [TIMEOUT_W-1:0]           cycle_count
);
   localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
   localparam int DW = ERR_DRAIN > 1 ? $clog2(ERR_DRAIN) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(ERR_DRAIN > 0 ? ERR_DRAIN - 1 : 0);
   typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [HW-1:0] hold_cnt, hold_cnt_nx;
   logic [DW-1:0] drain_cnt, drain_cnt_nx;
   logic [TIMEOUT_W-1:0] timer, timer_nx, cycle_count_nx;
   logic [NUM_CORES-1:0] sticky, sticky_nx, core_any;
   logic [NUM_LANES-1:0] lane_all;
   logic [NUM_ERR-1:0] err_src_nx;
   logic halt_hit, pass_nx, fail_timeout_nx, fail_error_nx;

   always_comb begin
      lane_all = '1;
      for (int c = 0; c < NUM_CORES; c++) begin
         core_any[c] = |halt[c*NUM_LANES +: NUM_LANES];
         lane_all &= halt[c*NUM_LANES +: NUM_LANES];
      end
      halt_hit = HALT_MODE == 0 ? |lane_all : HALT_MODE == 1 ? |halt : &(sticky | core_any);
   end

   // timer == 0 after load means the timeout is disabled; an enabled timer stops at 1
   always_comb begin
      state_nx = state;
      hold_cnt_nx = hold_cnt;
      drain_cnt_nx = drain_cnt;
      timer_nx = timer;
      sticky_nx = sticky;
      err_src_nx = err_src;
      cycle_count_nx = cycle_count;
      pass_nx = pass;
      fail_timeout_nx = fail_timeout;
      fail_error_nx = fail_error;
      case (state)
         HOLD:
            if (hold_cnt == HOLD_LAST) begin
               state_nx = RUN;
               timer_nx = timeout_cycles;
            end else hold_cnt_nx = hold_cnt + HW'(1);
         RUN: begin
            cycle_count_nx = cycle_count + TIMEOUT_W'(cycle_count != '1);
            sticky_nx = sticky | core_any;
            if (|err) begin
               err_src_nx = err;
               state_nx = ERR_DRAIN == 0 ? DONE : DRAIN;
               fail_error_nx = ERR_DRAIN == 0;
            end else if (halt_hit) begin
               state_nx = DONE;
               pass_nx = 1'b1;
            end else if (timer == TIMEOUT_W'(1)) begin
               state_nx = DONE;
               fail_timeout_nx = 1'b1;
            end else if (timer != '0) timer_nx = timer - TIMEOUT_W'(1);
         end
         DRAIN:
            if (drain_cnt == DRAIN_LAST) begin
               state_nx = DONE;
               fail_error_nx = 1'b1;
            end else drain_cnt_nx = drain_cnt + DW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= HOLD;
         hold_cnt <= '0;
         drain_cnt <= '0;
         timer <= '0;
         sticky <= '0;
         core_rst <= 1'b1;
         running <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         fail_timeout <= 1'b0;
         fail_error <= 1'b0;
         err_src <= '0;
         cycle_count <= '0;
      end else begin
         state <= state_nx;
         hold_cnt <= hold_cnt_nx;
         drain_cnt <= drain_cnt_nx;
         timer <= timer_nx;
         sticky <= sticky_nx;
         core_rst <= state_nx == HOLD;
         running <= state_nx == RUN;
         done <= state_nx == DONE;
         pass <= pass_nx;
         fail_timeout <= fail_timeout_nx;
         fail_error <= fail_error_nx;
         err_src <= err_src_nx;
         cycle_count <= cycle_count_nx;
      end
endmodule

// File: tb/tb_run_supervisor.sv
// tb_run_supervisor: three instances (halt modes 0/1/2) on shared stimulus, checked against a run-level model
module tb_run_supervisor;
   localparam int NC = 2, NL = 8, NE = 3, TW = 32, RH = 2;
   logic clk = 1'b0;
   logic rst;
   logic [NC*NL-1:0] halt;
   logic [NE-1:0] err;
   logic [TW-1:0] timeout_cycles;
   logic core_rst_o [3], running_o [3], done_o [3], pass_o [3], ft_o [3], fe_o [3];
   logic [NE-1:0] src_o [3];
   logic [TW-1:0] cc_o [3];
   int checks = 0, errors = 0;
   bit armed = 0;

   always #5 clk = ~clk;

   run_supervisor #(.NUM_CORES(NC), .NUM_LANES(NL), .NUM_ERR(NE), .TIMEOUT_W(TW), .RST_HOLD(RH), .ERR_DRAIN(5), .HALT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .halt(halt), .err(err), .timeout_cycles(timeout_cycles),
      .core_rst(core_rst_o[0]), .running(running_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .fail_timeout(ft_o[0]), .fail_error(fe_o[0]), .err_src(src_o[0]), .cycle_count(cc_o[0]));
   run_supervisor #(.NUM_CORES(NC), .NUM_LANES(NL), .NUM_ERR(NE), .TIMEOUT_W(TW), .RST_HOLD(RH), .ERR_DRAIN(0), .HALT_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .halt(halt), .err(err), .timeout_cycles(timeout_cycles),
      .core_rst(core_rst_o[1]), .running(running_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .fail_timeout(ft_o[1]), .fail_error(fe_o[1]), .err_src(src_o[1]), .cycle_count(cc_o[1]));
   run_supervisor #(.NUM_CORES(NC), .NUM_LANES(NL), .NUM_ERR(NE), .TIMEOUT_W(TW), .RST_HOLD(RH), .ERR_DRAIN(5), .HALT_MODE(2)) dut2 (
      .clk(clk), .rst(rst), .halt(halt), .err(err), .timeout_cycles(timeout_cycles),
      .core_rst(core_rst_o[2]), .running(running_o[2]), .done(done_o[2]), .pass(pass_o[2]),
      .fail_timeout(ft_o[2]), .fail_error(fe_o[2]), .err_src(src_o[2]), .cycle_count(cc_o[2]));

   // run-level model: edges since reset release, RUN cycles spent, verdict 0 none/1 pass/2 timeout/3 error
   typedef struct packed {
      logic [31:0] since;
      logic [1:0] verdict;
      logic [31:0] drain_left;
      logic [TW-1:0] runs;
      logic [TW-1:0] budget;
      logic [NC-1:0] seen;
      logic [NE-1:0] src;
   } mdl_t;
   mdl_t mdl [3];

   function automatic int drn(input int k);
      return k == 1 ? 0 : 5;
   endfunction

   function automatic logic halted(input int k, input logic [NC-1:0] seen, input logic [NC*NL-1:0] h);
      logic all;
      if (k == 1) return |h;
      if (k == 2) return &seen;
      for (int l = 0; l < NL; l++) begin
         all = 1'b1;
         for (int c = 0; c < NC; c++) all = all & h[c*NL+l];
         if (all) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int k, input logic [NC*NL-1:0] h, input logic [NE-1:0] e, input logic [TW-1:0] t);
      mdl_t n = m;
      if (n.since < RH) begin
         n.since = n.since + 1;
         if (n.since == RH) n.budget = t;
      end else if (n.drain_left != 0) begin
         n.drain_left = n.drain_left - 1;
         if (n.drain_left == 0) n.verdict = 2'd3;
      end else if (n.verdict == 2'd0) begin
         n.runs = n.runs + 1;
         for (int c = 0; c < NC; c++) if (|h[c*NL +: NL]) n.seen[c] = 1'b1;
         if (e != '0) begin
            n.src = e;
            if (drn(k) == 0) n.verdict = 2'd3;
            else n.drain_left = 32'(drn(k));
         end else if (halted(k, n.seen, h)) n.verdict = 2'd1;
         else if (n.budget != '0 && n.runs == n.budget) n.verdict = 2'd2;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst)
      for (int k = 0; k < 3; k++) mdl[k] <= rst ? '0 : step(mdl[k], k, halt, err, timeout_cycles);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (armed)
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d.core_rst", k), 32'(core_rst_o[k]), 32'(mdl[k].since < RH));
            chk($sformatf("dut%0d.running", k), 32'(running_o[k]), 32'(mdl[k].since >= RH && mdl[k].verdict == 2'd0 && mdl[k].drain_left == 0));
            chk($sformatf("dut%0d.done", k), 32'(done_o[k]), 32'(mdl[k].verdict != 2'd0));
            chk($sformatf("dut%0d.pass", k), 32'(pass_o[k]), 32'(mdl[k].verdict == 2'd1));
            chk($sformatf("dut%0d.fail_timeout", k), 32'(ft_o[k]), 32'(mdl[k].verdict == 2'd2));
            chk($sformatf("dut%0d.fail_error", k), 32'(fe_o[k]), 32'(mdl[k].verdict == 2'd3));
            chk($sformatf("dut%0d.err_src", k), 32'(src_o[k]), 32'(mdl[k].src));
            chk($sformatf("dut%0d.cycle_count", k), cc_o[k], mdl[k].runs);
         end

   // pulse rst from a negedge, release it, and return mid RUN cycle 0
   task automatic start(input logic [TW-1:0] tmo);
      #2 rst = 1'b1;
      halt = '0;
      err = '0;
      timeout_cycles = tmo;
      #1 chk("rst.core_rst", 32'(core_rst_o[0]), 32'd1);
      chk("rst.running", 32'(running_o[0]), 32'd0);
      chk("rst.cycle_count", cc_o[2], 32'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("hold.core_rst", 32'(core_rst_o[0]), 32'd1);
      chk("hold.running", 32'(running_o[0]), 32'd0);
      @(negedge clk);
      chk("run.core_rst", 32'(core_rst_o[0]), 32'd0);
      chk("run.running", 32'(running_o[0]), 32'd1);
      chk("run.done", 32'(done_o[0]), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      halt = '0;
      err = '0;
      timeout_cycles = '0;
      #1 rst = 1'b1;
      #1 armed = 1;
      @(negedge clk);
      // mode 0 same-lane halt at RUN cycle 20
      start(100);
      halt = 16'h2008;
      repeat (20) @(negedge clk);
      chk("m0.early_done", 32'(done_o[0]), 32'd0);
      chk("m1.any_pass", 32'(pass_o[1]), 32'd1);
      halt = 16'h2808;
      @(negedge clk);
      chk("m0.pass", 32'(pass_o[0]), 32'd1);
      chk("m0.done", 32'(done_o[0]), 32'd1);
      chk("m0.cycle_count", cc_o[0], 32'd21);
      err = 3'b100;
      repeat (3) @(negedge clk);
      chk("m0.done_ignores_err", 32'(fe_o[0]), 32'd0);
      chk("m0.done_src", 32'(src_o[0]), 32'd0);
      // timeout 10
      start(10);
      repeat (9) @(negedge clk);
      chk("to.early", 32'(done_o[0]), 32'd0);
      @(negedge clk);
      chk("to.fail_timeout", 32'(ft_o[0]), 32'd1);
      chk("to.cycle_count", cc_o[0], 32'd10);
      // timeout disabled
      start(0);
      repeat (1000) @(negedge clk);
      chk("to0.done", 32'(done_o[0]), 32'd0);
      chk("to0.cycle_count", cc_o[0], 32'd1000);
      // error drain
      start(100);
      repeat (7) @(negedge clk);
      err = 3'b010;
      @(negedge clk);
      chk("drain0.fail_error", 32'(fe_o[1]), 32'd1);
      chk("drain0.err_src", 32'(src_o[1]), 32'd2);
      err = 3'b111;
      halt = '1;
      repeat (4) @(negedge clk);
      chk("drain.early", 32'(done_o[0]), 32'd0);
      @(negedge clk);
      chk("drain.fail_error", 32'(fe_o[0]), 32'd1);
      chk("drain.err_src", 32'(src_o[0]), 32'd2);
      chk("drain.pass", 32'(pass_o[0]), 32'd0);
      // error + halt + expiry collide
      start(5);
      repeat (4) @(negedge clk);
      err = 3'b001;
      halt = '1;
      @(negedge clk);
      err = '0;
      halt = '0;
      repeat (5) @(negedge clk);
      chk("col3.fail_error", 32'(fe_o[0]), 32'd1);
      chk("col3.pass", 32'(pass_o[0]), 32'd0);
      chk("col3.fail_timeout", 32'(ft_o[0]), 32'd0);
      // halt + expiry collide
      start(5);
      repeat (4) @(negedge clk);
      halt = 16'h0101;
      @(negedge clk);
      halt = '0;
      chk("col2.pass", 32'(pass_o[0]), 32'd1);
      chk("col2.fail_timeout", 32'(ft_o[0]), 32'd0);
      chk("col2.cycle_count", cc_o[0], 32'd5);
      // mode 2 sticky halts
      start(100);
      repeat (4) @(negedge clk);
      halt = 16'h0002;
      @(negedge clk);
      halt = '0;
      repeat (4) @(negedge clk);
      chk("m2.early", 32'(done_o[2]), 32'd0);
      halt = 16'h4000;
      @(negedge clk);
      halt = '0;
      chk("m2.pass", 32'(pass_o[2]), 32'd1);
      chk("m2.cycle_count", cc_o[2], 32'd10);
      chk("m2.m1_cycle_count", cc_o[1], 32'd5);
      chk("m2.m0_done", 32'(done_o[0]), 32'd0);
      // mode 2 with reset abort between the two core halts
      start(100);
      repeat (4) @(negedge clk);
      halt = 16'h0002;
      @(negedge clk);
      halt = '0;
      @(negedge clk);
      chk("abort.no_pass", 32'(done_o[2]), 32'd0);
      start(100);
      chk("abort.cycle_count", cc_o[2], 32'd0);
      repeat (3) @(negedge clk);
      halt = 16'h4000;
      repeat (3) @(negedge clk);
      halt = '0;
      chk("abort.sticky_clear", 32'(done_o[2]), 32'd0);
      chk("abort.running", 32'(running_o[2]), 32'd1);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
